// File: rtl/button_event_classifier.sv
// Turns the debounced button level into short-press, long-press and double-click
// pulses, plus a held level while a long press is maintained.
module button_event_classifier #(
    parameter int CNT_W         = 16,
    parameter int LONG_TICKS    = 500,
    parameter int DBL_GAP_TICKS = 250
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_level,
    input  logic tick,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic held
);

    typedef enum logic [2:0] {
        ARM       = 3'd0,
        IDLE      = 3'd1,
        PRESS1    = 3'd2,
        LONG_HOLD = 3'd3,
        WAIT2     = 3'd4,
        PRESS2    = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(DBL_GAP_TICKS - 1);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             short_next;
    logic             long_next;
    logic             dbl_next;
    logic             held_next;
    logic             long_hit;
    logic             gap_hit;

    assign long_hit = tick && (cnt == LONG_LAST);
    assign gap_hit  = tick && (cnt == GAP_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ARM;
        end else begin
            state <= next_state;
        end
    end

    // Release beats the long threshold and a new press beats the gap timeout.
    always_comb begin
        next_state = ARM;
        case (state)
            ARM:       next_state = btn_level ? ARM : IDLE;
            IDLE:      next_state = btn_level ? PRESS1 : IDLE;
            PRESS1: begin
                if (!btn_level) begin
                    next_state = WAIT2;
                end else if (long_hit) begin
                    next_state = LONG_HOLD;
                end else begin
                    next_state = PRESS1;
                end
            end
            LONG_HOLD: next_state = btn_level ? LONG_HOLD : IDLE;
            WAIT2: begin
                if (btn_level) begin
                    next_state = PRESS2;
                end else if (gap_hit) begin
                    next_state = IDLE;
                end else begin
                    next_state = WAIT2;
                end
            end
            PRESS2:    next_state = btn_level ? PRESS2 : IDLE;
            default:   next_state = ARM;
        endcase
    end

    always_comb begin
        short_next = 1'b0;
        long_next  = 1'b0;
        dbl_next   = 1'b0;
        held_next  = (next_state == LONG_HOLD);
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (next_state == PRESS1) begin
                    cnt_next = '0;
                end
            end
            PRESS1: begin
                if (next_state == WAIT2) begin
                    cnt_next = '0;
                end else if (next_state == LONG_HOLD) begin
                    long_next = 1'b1;
                end else if (tick) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            WAIT2: begin
                if (next_state == PRESS2) begin
                    dbl_next = 1'b1;
                end else if (next_state == IDLE) begin
                    short_next = 1'b1;
                end else if (tick) begin
                    cnt_next = cnt + 1'b1;
                end
            end
            ARM, LONG_HOLD, PRESS2: cnt_next = cnt;
            default: cnt_next = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            short_press  <= 1'b0;
            long_press   <= 1'b0;
            double_click <= 1'b0;
            held         <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            short_press  <= short_next;
            long_press   <= long_next;
            double_click <= dbl_next;
            held         <= held_next;
        end
    end

endmodule

// File: tb/tb_button_event_classifier.sv
// Bench for button_event_classifier: directed press scenarios with literal timing
// expectations, then random button/tick traffic compared against an event model.
module tb_button_event_classifier;

    localparam int CNT_W         = 16;
    localparam int LONG_TICKS    = 4;
    localparam int DBL_GAP_TICKS = 3;

    logic clk       = 1'b0;
    logic rst_n     = 1'b0;
    logic btn_level = 1'b0;
    logic tick      = 1'b0;
    logic short_press;
    logic long_press;
    logic double_click;
    logic held;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int n_short, n_long, n_dbl, n_held;
    int short_cyc, long_cyc, dbl_cyc, last_held_cyc;

    // Model state: ticks counted during a first press / release gap, -1 when inactive.
    bit   m_blocked = 1'b1;
    bit   m_holding = 1'b0;
    int   m_down    = -1;
    int   m_up      = -1;
    logic exp_short = 1'b0;
    logic exp_long  = 1'b0;
    logic exp_dbl   = 1'b0;
    logic exp_held  = 1'b0;

    button_event_classifier #(
        .CNT_W        (CNT_W),
        .LONG_TICKS   (LONG_TICKS),
        .DBL_GAP_TICKS(DBL_GAP_TICKS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_level   (btn_level),
        .tick        (tick),
        .short_press (short_press),
        .long_press  (long_press),
        .double_click(double_click),
        .held        (held)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_blocked = 1'b1;
            m_holding = 1'b0;
            m_down    = -1;
            m_up      = -1;
            exp_short = 1'b0;
            exp_long  = 1'b0;
            exp_dbl   = 1'b0;
            exp_held  = 1'b0;
        end else begin
            exp_short = 1'b0;
            exp_long  = 1'b0;
            exp_dbl   = 1'b0;
            if (m_blocked) begin
                if (!btn_level) begin
                    m_blocked = 1'b0;
                    m_holding = 1'b0;
                end
            end else if (m_down >= 0) begin
                if (!btn_level) begin
                    m_down = -1;
                    m_up   = 0;
                end else if (tick) begin
                    m_down++;
                    if (m_down == LONG_TICKS) begin
                        exp_long  = 1'b1;
                        m_down    = -1;
                        m_blocked = 1'b1;
                        m_holding = 1'b1;
                    end
                end
            end else if (m_up >= 0) begin
                if (btn_level) begin
                    exp_dbl   = 1'b1;
                    m_up      = -1;
                    m_blocked = 1'b1;
                end else if (tick) begin
                    m_up++;
                    if (m_up == DBL_GAP_TICKS) begin
                        exp_short = 1'b1;
                        m_up      = -1;
                    end
                end
            end else if (btn_level) begin
                m_down = 0;
            end
            exp_held = m_holding;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    initial forever begin
        @(negedge clk);
        check_output("cyc_short", {31'b0, short_press}, {31'b0, exp_short});
        check_output("cyc_long", {31'b0, long_press}, {31'b0, exp_long});
        check_output("cyc_dbl", {31'b0, double_click}, {31'b0, exp_dbl});
        check_output("cyc_held", {31'b0, held}, {31'b0, exp_held});
        if (short_press)  begin n_short++; short_cyc = cyc; end
        if (long_press)   begin n_long++;  long_cyc  = cyc; end
        if (double_click) begin n_dbl++;   dbl_cyc   = cyc; end
        if (held)         begin n_held++;  last_held_cyc = cyc; end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic apply_stimulus(input logic b, input logic t, input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
            btn_level = b;
            tick      = t;
        end
    endtask

    task automatic clear_counts();
        n_short = 0; n_long = 0; n_dbl = 0; n_held = 0;
        short_cyc = -100; long_cyc = -100; dbl_cyc = -100; last_held_cyc = -100;
    endtask

    task automatic reset_now();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_output("rst_short", {31'b0, short_press}, 32'd0);
        check_output("rst_long", {31'b0, long_press}, 32'd0);
        check_output("rst_dbl", {31'b0, double_click}, 32'd0);
        check_output("rst_held", {31'b0, held}, 32'd0);
    endtask

    initial begin
        int p;
        int rel;
        logic b;
        int n;

        // Button held through reset and afterwards must not count as a press.
        btn_level = 1'b1;
        tick      = 1'b1;
        clear_counts();
        apply_stimulus(1'b1, 1'b1, 3);
        check_output("reset_held", {31'b0, held}, 32'd0);
        check_output("reset_short", {31'b0, short_press}, 32'd0);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 10);
        apply_stimulus(1'b0, 1'b1, 10);
        check_output("t1_pulses", n_short + n_long + n_dbl, 32'd0);
        check_output("t1_held", n_held, 32'd0);

        clear_counts();
        apply_stimulus(1'b1, 1'b1, 2);
        apply_stimulus(1'b0, 1'b1, 1);
        rel = cyc + 1;
        apply_stimulus(1'b0, 1'b1, 6);
        check_output("t2_short_n", n_short, 32'd1);
        check_output("t2_short_lat", short_cyc - rel, 32'd3);
        check_output("t2_others", n_long + n_dbl, 32'd0);

        clear_counts();
        apply_stimulus(1'b1, 1'b1, 1);
        p = cyc + 1;
        apply_stimulus(1'b1, 1'b1, 7);
        apply_stimulus(1'b0, 1'b1, 1);
        rel = cyc + 1;
        apply_stimulus(1'b0, 1'b1, 6);
        check_output("t3_long_n", n_long, 32'd1);
        check_output("t3_long_lat", long_cyc - p, 32'd4);
        check_output("t3_held_n", n_held, 32'd4);
        check_output("t3_held_end", last_held_cyc, rel - 1);
        check_output("t3_short_n", n_short, 32'd0);

        clear_counts();
        apply_stimulus(1'b1, 1'b1, 1);
        p = cyc + 1;
        apply_stimulus(1'b0, 1'b1, 1);
        apply_stimulus(1'b1, 1'b1, 2);
        apply_stimulus(1'b0, 1'b1, 6);
        check_output("t4_dbl_n", n_dbl, 32'd1);
        check_output("t4_dbl_lat", dbl_cyc - p, 32'd2);
        check_output("t4_others", n_short + n_long, 32'd0);

        // Release on the very edge the long threshold would be reached.
        clear_counts();
        apply_stimulus(1'b1, 1'b1, 4);
        apply_stimulus(1'b0, 1'b1, 1);
        rel = cyc + 1;
        apply_stimulus(1'b0, 1'b1, 6);
        check_output("t5_long_n", n_long, 32'd0);
        check_output("t5_short_n", n_short, 32'd1);
        check_output("t5_short_lat", short_cyc - rel, 32'd3);

        clear_counts();
        apply_stimulus(1'b1, 1'b0, 1);
        p = cyc + 1;
        for (int i = 1; i < 16; i++) begin
            apply_stimulus(1'b1, (i % 4) == 3, 1);
        end
        apply_stimulus(1'b0, 1'b1, 6);
        check_output("t5b_long_n", n_long, 32'd1);
        check_output("t5b_long_lat", long_cyc - p, 32'd15);
        check_output("t5b_short_n", n_short, 32'd0);

        // Reset mid-press, then button kept down: only a fresh press counts.
        clear_counts();
        apply_stimulus(1'b1, 1'b1, 3);
        reset_now();
        apply_stimulus(1'b1, 1'b1, 3);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 10);
        check_output("t6a_none", n_short + n_long + n_dbl, 32'd0);
        apply_stimulus(1'b0, 1'b1, 1);
        apply_stimulus(1'b1, 1'b1, 6);
        apply_stimulus(1'b0, 1'b1, 5);
        check_output("t6a_long_n", n_long, 32'd1);
        check_output("t6a_short_n", n_short, 32'd0);

        clear_counts();
        apply_stimulus(1'b1, 1'b1, 6);
        @(negedge clk);
        #2;
        check_output("t6b_held_pre", {31'b0, held}, 32'd1);
        reset_now();
        apply_stimulus(1'b1, 1'b1, 2);
        rst_n = 1'b1;
        apply_stimulus(1'b1, 1'b1, 8);
        apply_stimulus(1'b0, 1'b1, 4);
        apply_stimulus(1'b1, 1'b1, 1);
        apply_stimulus(1'b0, 1'b1, 1);
        rel = cyc + 1;
        apply_stimulus(1'b0, 1'b1, 5);
        check_output("t6b_long_n", n_long, 32'd1);
        check_output("t6b_short_n", n_short, 32'd1);
        check_output("t6b_short_lat", short_cyc - rel, 32'd3);
        check_output("t6b_dbl_n", n_dbl, 32'd0);

        for (int k = 0; k < 400; k++) begin
            b = 1'($urandom_range(0, 1));
            n = int'($urandom_range(1, 7));
            for (int j = 0; j < n; j++) begin
                apply_stimulus(b, $urandom_range(0, 3) != 0, 1);
            end
            if ($urandom_range(0, 99) == 0) begin
                reset_now();
                apply_stimulus(btn_level, 1'b1, 1);
                rst_n = 1'b1;
            end
        end
        apply_stimulus(1'b0, 1'b1, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
